// File: rtl/serial_subtractor_fsm.sv
// Bit-serial two's-complement subtractor, d = a - b - bin, LSB first.
// One full-subtractor cell with a registered borrow; start/busy/done handshake.
module serial_subtractor_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             a0, b0;
  logic             dbit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             accept;
  logic             last;

  // Full-subtractor cell on the current LSBs and the shifted result.
  always_comb begin
    a0      = a_q[0];
    b0      = b_q[0];
    dbit    = a0 ^ b0 ^ br_q;
    br_nxt  = (~a0 & b0) | (br_q & ~(a0 ^ b0));
    res_nxt = {dbit, res_q[WIDTH-1:1]};
    accept  = start & (state_q != S_RUN);
    last    = (cnt_q == LAST);
  end

  // Next-state and datapath update; outputs are computed here and registered.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (1'b1)
      (state_q == S_RUN): begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_nxt;
        br_d  = br_nxt;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          d_d     = res_nxt;
          bout_d  = br_nxt;
          ovf_d   = (amsb_q != bmsb_q) & (dbit != amsb_q);
          zero_d  = (res_nxt == '0);
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      accept: begin
        state_d = S_RUN;
        a_d     = a;
        b_d     = b;
        br_d    = bin;
        cnt_d   = '0;
        amsb_d  = a[WIDTH-1];
        bmsb_d  = b[WIDTH-1];
        busy_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Directed bench for serial_subtractor_fsm at WIDTH=8 and WIDTH=4.
// Outputs are sampled on the falling clock edge.
module tb_serial_subtractor_fsm;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       s8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, ovf8, zero8;
  logic [7:0] d8;

  logic       s4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4, ovf4, zero4;
  logic [3:0] d4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8),
    .zero(zero8)
  );

  serial_subtractor_fsm #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4),
    .zero(zero4)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic ci, input logic [7:0] ed,
                     input logic eb, input logic eo, input logic ez,
                     input bit glitch);
    int lat;
    int nb;
    s8 = 1'b1; a8 = ai; b8 = bi; bin8 = ci;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; bin8 = 1'b1;
    lat = 0; nb = 0;
    while (!done8 && lat < 40) begin
      if (busy8) nb++;
      s8 = (glitch && lat == 3);
      if (s8) begin a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; end
      @(negedge clk);
      lat++;
    end
    s8 = 1'b0;
    chk("lat8", 64'(lat), 64'd8);
    chk("busycyc8", 64'(nb), 64'd8);
    chk("busy_at_done8", 64'(busy8), 64'd0);
    chk("d8", 64'(d8), 64'(ed));
    chk("bout8", 64'(bout8), 64'(eb));
    chk("ovf8", 64'(ovf8), 64'(eo));
    chk("zero8", 64'(zero8), 64'(ez));
    @(negedge clk);
    chk("done_pulse8", 64'(done8), 64'd0);
    chk("d_hold8", 64'(d8), 64'(ed));
  endtask

  task automatic op4(input int ai, input int bi, input int ci);
    int lat;
    int diff;
    int sres;
    int sa;
    int sb;
    s4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0];
    @(negedge clk);
    s4 = 1'b0; a4 = 4'(~ai); b4 = 4'(~bi); bin4 = ~ci[0];
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    diff = ai - bi - ci;
    sa   = (ai >= 8) ? ai - 16 : ai;
    sb   = (bi >= 8) ? bi - 16 : bi;
    sres = sa - sb - ci;
    chk("lat4", 64'(lat), 64'd4);
    chk("d4", 64'(d4), 64'(diff & 15));
    chk("bout4", 64'(bout4), 64'(diff < 0));
    chk("ovf4", 64'(ovf4), 64'(sres > 7 || sres < -8));
    chk("zero4", 64'(zero4), 64'((diff & 15) == 0));
  endtask

  initial begin
    int n;
    int seen;
    rst_n = 1'b0;
    s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_d", 64'(d8), 64'd0);
    chk("rst_flags", 64'({bout8, ovf8, zero8}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    s8 = 1'b1; a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_lat", 64'(n), 64'd8);
    chk("b2b_first_d", 64'(d8), 64'h1F);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 40);
    s8 = 1'b0;
    chk("b2b_spacing", 64'(n), 64'd9);
    chk("b2b_second_d", 64'(d8), 64'h05);
    @(negedge clk);

    s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_d", 64'(d8), 64'd0);
    chk("abort_flags", 64'({bout8, ovf8, zero8}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    op8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          op4(ia, ib, ic);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
